// File: rtl/instruction_fetch.sv
// instruction_fetch: IF stage with byte-loaded instruction memory and IF/ID register.
// Ports: i_pc/i_pc4 fetch address, i_stall/i_flush/i_halt IF/ID control, i_load_* debug loader; o_instr/o_pc4 IF/ID, o_halt_fetched, o_load_* loader status.
module instruction_fetch #(
  parameter int          MEM_WORDS  = 64,
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h00000000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [31:0]                i_pc,
  input  logic [31:0]                i_pc4,
  input  logic                       i_stall,
  input  logic                       i_flush,
  input  logic                       i_halt,
  input  logic                       i_load_en,
  input  logic [7:0]                 i_load_byte,
  input  logic                       i_load_clear,
  output logic [31:0]                o_instr,
  output logic [31:0]                o_pc4,
  output logic                       o_halt_fetched,
  output logic                       o_load_word_done,
  output logic [$clog2(MEM_WORDS):0] o_load_count
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE, S_ASSEMBLE} state_t;

  state_t        r_state;
  logic [1:0]    r_byte_cnt;
  logic [23:0]   r_shift;
  logic [AW-1:0] r_load_ptr;
  logic [31:0]   r_mem [MEM_WORDS];

  logic [AW-1:0] w_rd_addr;
  logic [31:0]   w_fetch;
  logic [31:0]   w_wr_data;
  logic          w_wr_en;
  logic          w_unused;

  assign w_rd_addr      = i_pc[AW+1:2];
  assign w_fetch        = r_mem[w_rd_addr];
  assign o_halt_fetched = (w_fetch == HALT_INSTR);
  assign w_unused       = &{1'b0, i_pc[31:AW+2], i_pc[1:0]};

  // The fourth byte completes the word; clear drops a coincident byte.
  assign w_wr_en   = i_load_en && !i_load_clear
                   && (r_byte_cnt == 2'd3);
  assign w_wr_data = {r_shift, i_load_byte};

  // Memory has no reset so a loaded program survives reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[r_load_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_instr <= NOP_INSTR;
      o_pc4   <= '0;
    end else if (i_flush) begin
      o_instr <= NOP_INSTR;
      o_pc4   <= i_pc4;
    end else if (!(i_stall || i_halt)) begin
      o_instr <= w_fetch;
      o_pc4   <= i_pc4;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state          <= S_IDLE;
      r_byte_cnt       <= 2'd0;
      r_shift          <= '0;
      r_load_ptr       <= '0;
      o_load_count     <= '0;
      o_load_word_done <= 1'b0;
    end else begin
      o_load_word_done <= 1'b0;
      if (i_load_clear) begin
        r_state      <= S_IDLE;
        r_byte_cnt   <= 2'd0;
        r_shift      <= '0;
        r_load_ptr   <= '0;
        o_load_count <= '0;
      end else if (i_load_en) begin
        unique case (r_state)
          S_IDLE: begin
            r_state    <= S_ASSEMBLE;
            r_byte_cnt <= 2'd1;
            r_shift    <= {16'h0, i_load_byte};
          end
          S_ASSEMBLE: begin
            if (r_byte_cnt == 2'd3) begin
              r_state          <= S_IDLE;
              r_byte_cnt       <= 2'd0;
              r_load_ptr       <= r_load_ptr + 1'b1;
              o_load_word_done <= 1'b1;
              if (o_load_count != CW'(MEM_WORDS)) begin
                o_load_count <= o_load_count + 1'b1;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              r_shift    <= {r_shift[15:0], i_load_byte};
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter MEM_WORDS, default 64; instruction memory depth in 32-bit words; power of two.
REQ-002 Parameter HALT_INSTR, default 32'hFFFFFFFF; encoding that stops the pipeline.
REQ-003 Parameter NOP_INSTR, default 32'h00000000; bubble inserted on flush.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  reset; asynchronous, active-low.
REQ-006 i_pc  input  32  byte address of the instruction to fetch, supplied by PC control.
REQ-007 i_pc4  input  32  i_pc + 4, supplied by PC control.
REQ-008 i_stall  input  1  hazard stall; hold IF/ID contents.
REQ-009 i_flush  input  1  taken jump or branch; replace IF/ID contents with a bubble.
REQ-010 i_halt  input  1  pipeline halted by the debug unit; hold IF/ID contents.
REQ-011 i_load_en  input  1  one program byte valid on i_load_byte this cycle.
REQ-012 i_load_byte  input  8  program byte from the debug loader.
REQ-013 i_load_clear  input  1  restart loading at word 0, byte 0.
REQ-014 o_instr  output  32  IF/ID registered instruction.
REQ-015 o_pc4  output  32  IF/ID registered pc+4.
REQ-016 o_halt_fetched  output  1  combinational; high when the word at i_pc equals HALT_INSTR.
REQ-017 o_load_word_done  output  1  one-cycle pulse when a complete word has been written.
REQ-018 o_load_count  output  $clog2(MEM_WORDS)+1  number of words written since the last clear.

Function
REQ-019 Fetch is an asynchronous read of word i_pc[$clog2(MEM_WORDS)+1:2]; i_pc[1:0] and higher bits are ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-020 IF/ID register update priority per edge: i_flush, then (i_stall or i_halt), then normal load.
REQ-021 On i_flush: o_instr <= NOP_INSTR and o_pc4 <= i_pc4, even when i_stall or i_halt is also high.
REQ-022 On hold (i_stall or i_halt, no flush): o_instr and o_pc4 keep their values.
REQ-023 On normal load: o_instr <= fetched word and o_pc4 <= i_pc4; latency is one cycle from i_pc to o_instr.
REQ-024 o_halt_fetched follows the fetched word with no register, so PC control sees it in the same cycle.
REQ-025 Loader FSM states: IDLE (byte_cnt=0) and ASSEMBLE (byte_cnt=1..3); a 24-bit shift register holds the partial word.
REQ-026 Bytes are assembled big-endian: the first byte is word[31:24] and the fourth is word[7:0].
REQ-027 A byte with i_load_en in IDLE moves the FSM to ASSEMBLE with byte_cnt=1; each further byte increments byte_cnt.
REQ-028 The fourth byte writes the word at address load_ptr, increments load_ptr and o_load_count, pulses o_load_word_done for one cycle, and returns the FSM to IDLE.
REQ-029 load_ptr wraps from MEM_WORDS-1 to 0; o_load_count saturates at MEM_WORDS.
REQ-030 i_load_clear sets the FSM to IDLE and zeroes byte_cnt, load_ptr and o_load_count, discarding any partial word.
REQ-031 i_load_clear has priority over a coincident i_load_en; that byte is dropped.
REQ-032 Cycles with i_load_en low leave the loader state unchanged, so partial words survive gaps.
REQ-033 A memory write and a fetch of the same word in the same cycle return the old contents; the new word is visible on the next cycle.
REQ-034 Loading is legal only while i_halt=1; behaviour when loading with i_halt=0 is unspecified, and the verification bench checks this with an assertion.

Reset
REQ-035 While i_reset=0: o_instr=NOP_INSTR, o_pc4=0, o_load_word_done=0, o_load_count=0, load_ptr=0, FSM in IDLE, partial word cleared.
REQ-036 Instruction memory contents are not affected by reset, so a loaded program survives a reset.
REQ-037 Reset asserted in the middle of a word discards the partial word; loading restarts at word 0, byte 0 after release.

Verification
REQ-038 Load bytes 20,08,00,05 then FF,FF,FF,FF with i_halt=1 -> o_load_word_done pulses twice, o_load_count=2, mem[0]=32'h20080005, mem[1]=32'hFFFFFFFF.
REQ-039 Release i_halt with i_pc=0 then i_pc=4 -> o_instr=32'h20080005 with o_pc4=4, then o_instr=32'hFFFFFFFF; o_halt_fetched=1 while i_pc=4.
REQ-040 Set i_stall=1 for 2 cycles while i_pc changes -> o_instr and o_pc4 stay constant; with i_flush=1 and i_stall=1 together -> o_instr=0.
REQ-041 Send 2 bytes, then i_load_clear together with a third byte, then 4 bytes AA,BB,CC,DD -> mem[0]=32'hAABBCCDD and o_load_count=1.
REQ-042 Pull i_reset low after 3 bytes of a word -> outputs return to the reset values and the next 4 bytes write word 0; previously loaded words are unchanged.
REQ-043 Load MEM_WORDS+1 words -> load_ptr wraps and the last word overwrites word 0; o_load_count=MEM_WORDS.
